// File: rtl/minmax_pkg.sv
// Shared types and constants for the streaming min/max reducer.
package minmax_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic MODE_MIN = 1'b0;
  localparam logic MODE_MAX = 1'b1;

endpackage

// File: rtl/cmp_int_nbit.sv
// Strict greater-than comparator for signed or unsigned WIDTH-bit operands.
module cmp_int_nbit #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             is_signed,
  output logic             a_gt_b
);

  logic [WIDTH-1:0] a_k;
  logic [WIDTH-1:0] b_k;

  // Flipping the sign bit maps two's-complement order onto unsigned order.
  always_comb begin
    a_k = a;
    b_k = b;
    if (is_signed) begin
      a_k[WIDTH-1] = ~a[WIDTH-1];
      b_k[WIDTH-1] = ~b[WIDTH-1];
    end
    a_gt_b = (a_k > b_k);
  end

endmodule

// File: rtl/minmax_reduce_nbit.sv
// Reduces a framed stream of operands to its minimum or maximum, reporting
// the winner's value, first position, beat count and an overflow flag.
module minmax_reduce_nbit
  import minmax_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int IDX_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mode_max,
  input  logic             is_signed,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [IDX_W-1:0] out_index,
  output logic [IDX_W-1:0] out_count,
  output logic             out_ovf
);

  localparam logic [IDX_W-1:0] CNT_MAX = '1;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             mode_q, mode_d;
  logic             sgn_q, sgn_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [IDX_W-1:0] out_index_q, out_index_d;
  logic [IDX_W-1:0] out_count_q, out_count_d;
  logic             out_ovf_q, out_ovf_d;

  logic             accept;
  logic [WIDTH-1:0] cmp_a;
  logic [WIDTH-1:0] cmp_b;
  logic             better;

  assign accept = in_valid & in_ready_q;

  // Operands are swapped so one strict '>' serves both min and max.
  assign cmp_a = (mode_q == MODE_MAX) ? in_data : acc_q;
  assign cmp_b = (mode_q == MODE_MAX) ? acc_q   : in_data;

  cmp_int_nbit #(
    .WIDTH (WIDTH)
  ) u_cmp (
    .a         (cmp_a),
    .b         (cmp_b),
    .is_signed (sgn_q),
    .a_gt_b    (better)
  );

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    mode_d      = mode_q;
    sgn_d       = sgn_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_index_d = out_index_q;
    out_count_d = out_count_q;
    out_ovf_d   = out_ovf_q;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          acc_d   = in_data;
          idx_d   = '0;
          cnt_d   = IDX_W'(1);
          ovf_d   = 1'b0;
          mode_d  = mode_max;
          sgn_d   = is_signed;
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        if (accept) begin
          // cnt_q is the new beat's position, already clamped at CNT_MAX.
          if (better) begin
            acc_d = in_data;
            idx_d = cnt_q;
          end
          if (cnt_q == CNT_MAX) begin
            ovf_d = 1'b1;
          end else begin
            cnt_d = cnt_q + IDX_W'(1);
          end
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d     = IDLE;
          in_ready_d  = 1'b1;
          out_valid_d = 1'b0;
        end
      end
      default: begin
        state_d     = IDLE;
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
      end
    endcase

    // Result registers are only loaded here, so they hold between sets.
    if (accept && in_last) begin
      state_d     = DONE;
      in_ready_d  = 1'b0;
      out_valid_d = 1'b1;
      out_data_d  = acc_d;
      out_index_d = idx_d;
      out_count_d = cnt_d;
      out_ovf_d   = ovf_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      idx_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      mode_q      <= MODE_MIN;
      sgn_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_index_q <= '0;
      out_count_q <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      mode_q      <= mode_d;
      sgn_q       <= sgn_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_index_q <= out_index_d;
      out_count_q <= out_count_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_index = out_index_q;
  assign out_count = out_count_q;
  assign out_ovf   = out_ovf_q;

endmodule

// File: doc/minmax_reduce_nbit.md
MINMAX_REDUCE_NBIT -- requirements
Module: minmax_reduce_nbit

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand width in bits (2..64).
REQ-002 SHALL have parameter IDX_W, default 8, width of index/count fields.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port mode_max  input  1  0 = minimum, 1 = maximum; sampled on first beat of a set.
REQ-006 SHALL have port is_signed  input  1  1 = two's-complement compare, 0 = unsigned; sampled on first beat.
REQ-007 SHALL have port in_valid  input  1  input beat valid.
REQ-008 SHALL have port in_ready  output  1  block can accept a beat.
REQ-009 SHALL have port in_data  input  WIDTH  operand.
REQ-010 SHALL have port in_last  input  1  marks final beat of a set.
REQ-011 SHALL have port out_valid  output  1  result valid.
REQ-012 SHALL have port out_ready  input  1  consumer accepts result.
REQ-013 SHALL have port out_data  output  WIDTH  winning value.
REQ-014 SHALL have port out_index  output  IDX_W  zero-based position of winner in set.
REQ-015 SHALL have port out_count  output  IDX_W  number of beats in set, saturating.
REQ-016 SHALL have port out_ovf  output  1  set length exceeded 2^IDX_W-1.

Function
REQ-017 SHALL implement FSM states IDLE, ACCUM, DONE.
REQ-018 SHALL drive in_ready=1 in IDLE and ACCUM, 0 in DONE.
REQ-019 Beat accepted when in_valid & in_ready on a rising edge.
REQ-020 IDLE accept: acc<=in_data, idx<=0, cnt<=1, latch mode_max/is_signed; go ACCUM, or DONE if in_last.
REQ-021 ACCUM accept: replace acc and set idx<=cnt only if new operand strictly better (min: less, max: greater) under latched signedness; cnt increments.
REQ-022 Ties SHALL keep the earliest element (lowest index).
REQ-023 Changes of mode_max/is_signed after the first beat SHALL be ignored until the next set.
REQ-024 ACCUM accept with in_last SHALL go DONE; out_valid asserts the next cycle (latency 1 from last beat).
REQ-025 In DONE, out_valid=1 and out_data/out_index/out_count/out_ovf SHALL be stable until out_valid & out_ready, then go IDLE.
REQ-026 Single-beat set: out_index=0, out_count=1.
REQ-027 cnt SHALL saturate at 2^IDX_W-1 and set ovf sticky for the set; a winner at or after saturation reports out_index=2^IDX_W-1.
REQ-028 out_valid=0 outside DONE; out_* data holds last value.
REQ-029 Signed compare SHALL order 0x8000 < 0x7FFF for WIDTH=16; unsigned the reverse.

Reset
REQ-030 rst SHALL asynchronously force IDLE; in_ready=1 when rst deasserted; out_valid=0, out_data=0, out_index=0, out_count=0, out_ovf=0.
REQ-031 rst mid-set or in DONE SHALL discard partial/pending result with no output beat.

Structure
REQ-032 Package minmax_pkg SHALL hold the FSM state enum and MODE_MIN/MODE_MAX constants.
REQ-033 Strict compare SHALL be a combinational sub-module cmp_int_nbit (WIDTH, is_signed -> A>B).
REQ-034 Datapath, FSM and counters SHALL reside in minmax_reduce_nbit; no other sub-modules.

Verification
REQ-035 Unsigned min, beats 5,3,9,3(last) -> out_data=3, out_index=1, out_count=4, one cycle after last.
REQ-036 Signed max, beats 0xFFFF,0x8000,0x0001(last) -> out_data=0x0001, out_index=2; same set unsigned max -> 0xFFFF, index 0.
REQ-037 out_ready held 0 for 5 cycles in DONE -> in_ready=0, outputs stable, then released -> IDLE, new set accepted next cycle.
REQ-038 IDX_W=3, nine beats with max at beat 8 -> out_count=7, out_index=7, out_ovf=1.
REQ-039 rst asserted after 2 beats of a set -> out_valid never rises; next set 7(last) -> out_data=7, out_count=1.
REQ-040 mode_max toggled mid-set -> result follows mode latched at first beat.
